int_seq: RTL and testbench

INT_SEQ -- requirements
Module: int_seq

---
 rtl/int_seq.sv | 178 +++++++++++++++++
 tb/tb_int_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_seq.sv
// Interrupt/reset entry sequencer: stacks PC and P, then fetches the vector.
// Define INT_SEQ_BRK_EN to add the brk_req input and B-bit push support.
module int_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic        boundary,
  input  logic [7:0]  s_in,
  output logic        busy,
  output logic [1:0]  cause,
  output logic [15:0] addr,
  output logic [1:0]  wdata_sel,
  output logic        mem_we,
  output logic        s_dec,
  output logic        pcl_ld,
  output logic        pch_ld,
  output logic        set_i,
  output logic        push_b
`ifdef INT_SEQ_BRK_EN
  ,
  input  logic        brk_req
`endif
);

  localparam logic [7:0] STACK_PAGE = 8'h01;
  localparam logic [7:0] VEC_BASE   = 8'hFF;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_RST  = 2'b01;
  localparam logic [1:0] C_NMI  = 2'b10;
  localparam logic [1:0] C_IRQ  = 2'b11;

  typedef enum logic [2:0] {
    RST_WAIT,
    IDLE,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_P,
    VEC_L,
    VEC_H
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       nmi_lat_q, nmi_lat_d;
  logic       nmi_prev_q;
  logic       nmi_fall;
  logic       irq_pend;
  logic       hijack;
  logic       brk_start;
  logic [1:0] vcause;
  logic [7:0] vec_lo;

  assign nmi_fall = nmi_prev_q & ~nmi_n;
  assign irq_pend = ~irq_n & ~i_flag;
  assign hijack   = (cause_q == C_IRQ) & nmi_lat_q;

  // A late NMI steals the vector fetch of an IRQ/BRK sequence.
  assign vcause = (state_q == VEC_L && hijack) ? C_NMI : cause_q;

  always_comb begin
    vec_lo = 8'hFE;
    unique case (vcause)
      C_RST:   vec_lo = 8'hFC;
      C_NMI:   vec_lo = 8'hFA;
      default: vec_lo = 8'hFE;
    endcase
  end

`ifdef INT_SEQ_BRK_EN
  logic brk_q;

  assign brk_start = brk_req;
  assign push_b    = (state_q == PUSH_P) & brk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_q <= 1'b0;
    end else if (state_q == IDLE && boundary) begin
      brk_q <= brk_req & ~nmi_lat_q;
    end
  end
`else
  assign brk_start = 1'b0;
  assign push_b    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    nmi_lat_d = nmi_lat_q | nmi_fall;
    busy      = 1'b1;
    cause     = cause_q;
    addr      = 16'h0000;
    wdata_sel = 2'b00;
    mem_we    = 1'b0;
    s_dec     = 1'b0;
    pcl_ld    = 1'b0;
    pch_ld    = 1'b0;
    set_i     = 1'b0;
    unique case (state_q)
      RST_WAIT: begin
        cause   = C_RST;
        cause_d = C_RST;
        state_d = VEC_L;
      end
      IDLE: begin
        busy  = 1'b0;
        cause = C_NONE;
        if (boundary) begin
          if (nmi_lat_q) begin
            state_d   = PUSH_PCH;
            cause_d   = C_NMI;
            nmi_lat_d = nmi_fall;
          end else if (irq_pend || brk_start) begin
            state_d = PUSH_PCH;
            cause_d = C_IRQ;
          end
        end
      end
      PUSH_PCH, PUSH_PCL, PUSH_P: begin
        addr   = {STACK_PAGE, s_in};
        mem_we = 1'b1;
        s_dec  = 1'b1;
        unique case (state_q)
          PUSH_PCH: begin
            wdata_sel = 2'b00;
            state_d   = PUSH_PCL;
          end
          PUSH_PCL: begin
            wdata_sel = 2'b01;
            state_d   = PUSH_P;
          end
          default: begin
            wdata_sel = 2'b10;
            state_d   = VEC_L;
          end
        endcase
      end
      VEC_L: begin
        cause   = vcause;
        addr    = {VEC_BASE, vec_lo};
        pcl_ld  = 1'b1;
        state_d = VEC_H;
        if (hijack) begin
          cause_d   = C_NMI;
          nmi_lat_d = nmi_fall;
        end
      end
      VEC_H: begin
        addr    = {VEC_BASE, vec_lo | 8'h01};
        pch_ld  = 1'b1;
        set_i   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = RST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_WAIT;
      cause_q    <= C_RST;
      nmi_lat_q  <= 1'b0;
      nmi_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      nmi_lat_q  <= nmi_lat_d;
      nmi_prev_q <= nmi_n;
    end
  end

endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq: reset fetch, IRQ, NMI hijack, late NMI, abort.
// Exercises the BRK path when INT_SEQ_BRK_EN is defined.
module tb_int_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        nmi_n;
  logic        irq_n;
  logic        i_flag;
  logic        boundary;
  logic [7:0]  s_in;
  logic        busy;
  logic [1:0]  cause;
  logic [15:0] addr;
  logic [1:0]  wdata_sel;
  logic        mem_we;
  logic        s_dec;
  logic        pcl_ld;
  logic        pch_ld;
  logic        set_i;
  logic        push_b;
`ifdef INT_SEQ_BRK_EN
  logic        brk_req;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // strobe vector order: mem_we, s_dec, pcl_ld, pch_ld, set_i, push_b
  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_PUSH  = 6'b110000;
  localparam logic [5:0] S_PUSHB = 6'b110001;
  localparam logic [5:0] S_VL    = 6'b001000;
  localparam logic [5:0] S_VH    = 6'b000111 & 6'b111110;

  int_seq dut (
    .clk       (clk),
    .rst       (rst),
    .nmi_n     (nmi_n),
    .irq_n     (irq_n),
    .i_flag    (i_flag),
    .boundary  (boundary),
    .s_in      (s_in),
    .busy      (busy),
    .cause     (cause),
    .addr      (addr),
    .wdata_sel (wdata_sel),
    .mem_we    (mem_we),
    .s_dec     (s_dec),
    .pcl_ld    (pcl_ld),
    .pch_ld    (pch_ld),
    .set_i     (set_i),
    .push_b    (push_b)
`ifdef INT_SEQ_BRK_EN
    ,
    .brk_req   (brk_req)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic b,
                     input logic [1:0] c, input logic [15:0] a,
                     input logic [1:0] w, input logic [5:0] s);
    logic [26:0] obs;
    logic [26:0] exp;
    obs = {busy, cause, addr, wdata_sel,
           mem_we, s_dec, pcl_ld, pch_ld, set_i, push_b};
    exp = {b, c, a, w, s};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    nmi_n    = 1'b1;
    irq_n    = 1'b1;
    i_flag   = 1'b1;
    boundary = 1'b0;
    s_in     = 8'hFD;
`ifdef INT_SEQ_BRK_EN
    brk_req  = 1'b0;
`endif
    #1;
    chk("reset_state", 1'b1, 2'b01, 16'h0000, 2'b00, S_NONE);
    tick();
    tick();
    chk("reset_hold", 1'b1, 2'b01, 16'h0000, 2'b00, S_NONE);

    rst = 1'b0;
    tick();
    chk("rst_vec_l", 1'b1, 2'b01, 16'hFFFC, 2'b00, S_VL);
    tick();
    chk("rst_vec_h", 1'b1, 2'b01, 16'hFFFD, 2'b00, S_VH);
    tick();
    chk("rst_idle", 1'b0, 2'b00, 16'h0000, 2'b00, S_NONE);

    // IRQ low but no boundary: must not start
    irq_n  = 1'b0;
    i_flag = 1'b0;
    tick();
    chk("irq_no_bnd", 1'b0, 2'b00, 16'h0000, 2'b00, S_NONE);

    // plain IRQ sequence
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    chk("irq_pch", 1'b1, 2'b11, 16'h01FD, 2'b00, S_PUSH);
    tick();
    chk("irq_pcl", 1'b1, 2'b11, 16'h01FD, 2'b01, S_PUSH);
    tick();
    chk("irq_p", 1'b1, 2'b11, 16'h01FD, 2'b10, S_PUSH);
    tick();
    chk("irq_vec_l", 1'b1, 2'b11, 16'hFFFE, 2'b00, S_VL);
    tick();
    chk("irq_vec_h", 1'b1, 2'b11, 16'hFFFF, 2'b00, S_VH);
    tick();
    chk("irq_done", 1'b0, 2'b00, 16'h0000, 2'b00, S_NONE);

    // masked IRQ
    i_flag   = 1'b1;
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    chk("irq_masked", 1'b0, 2'b00, 16'h0000, 2'b00, S_NONE);

    // NMI edge during PUSH_PCL hijacks the vector
    i_flag   = 1'b0;
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    irq_n    = 1'b1;
    tick();
    nmi_n = 1'b0;
    chk("hj_pcl", 1'b1, 2'b11, 16'h01FD, 2'b01, S_PUSH);
    tick();
    chk("hj_p", 1'b1, 2'b11, 16'h01FD, 2'b10, S_PUSH);
    tick();
    chk("hj_vec_l", 1'b1, 2'b10, 16'hFFFA, 2'b00, S_VL);
    tick();
    chk("hj_vec_h", 1'b1, 2'b10, 16'hFFFB, 2'b00, S_VH);
    tick();
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    chk("hj_no_2nd", 1'b0, 2'b00, 16'h0000, 2'b00, S_NONE);
    nmi_n = 1'b1;
    tick();

    // NMI edge during VEC_H: IRQ completes, NMI runs next
    irq_n    = 1'b0;
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    tick();
    tick();
    tick();
    chk("late_vec_l", 1'b1, 2'b11, 16'hFFFE, 2'b00, S_VL);
    tick();
    nmi_n = 1'b0;
    chk("late_vec_h", 1'b1, 2'b11, 16'hFFFF, 2'b00, S_VH);
    tick();
    chk("late_idle", 1'b0, 2'b00, 16'h0000, 2'b00, S_NONE);
    // IRQ still pending here; NMI must win
    s_in     = 8'hF0;
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    irq_n    = 1'b1;
    chk("nmi_pch", 1'b1, 2'b10, 16'h01F0, 2'b00, S_PUSH);
    tick();
    tick();
    chk("nmi_p", 1'b1, 2'b10, 16'h01F0, 2'b10, S_PUSH);
    tick();
    chk("nmi_vec_l", 1'b1, 2'b10, 16'hFFFA, 2'b00, S_VL);
    tick();
    chk("nmi_vec_h", 1'b1, 2'b10, 16'hFFFB, 2'b00, S_VH);
    tick();
    chk("nmi_idle", 1'b0, 2'b00, 16'h0000, 2'b00, S_NONE);
    nmi_n = 1'b1;
    tick();

    // reset during PUSH_P aborts the sequence
    s_in     = 8'hFD;
    irq_n    = 1'b0;
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    irq_n    = 1'b1;
    tick();
    tick();
    chk("ab_p", 1'b1, 2'b11, 16'h01FD, 2'b10, S_PUSH);
    rst = 1'b1;
    #1;
    chk("ab_async", 1'b1, 2'b01, 16'h0000, 2'b00, S_NONE);
    tick();
    chk("ab_hold", 1'b1, 2'b01, 16'h0000, 2'b00, S_NONE);
    rst = 1'b0;
    tick();
    chk("ab_vec_l", 1'b1, 2'b01, 16'hFFFC, 2'b00, S_VL);
    tick();
    chk("ab_vec_h", 1'b1, 2'b01, 16'hFFFD, 2'b00, S_VH);
    tick();
    chk("ab_idle", 1'b0, 2'b00, 16'h0000, 2'b00, S_NONE);

`ifdef INT_SEQ_BRK_EN
    // BRK ignores the I flag and pushes B=1
    i_flag   = 1'b1;
    brk_req  = 1'b1;
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    brk_req  = 1'b0;
    chk("brk_pch", 1'b1, 2'b11, 16'h01FD, 2'b00, S_PUSH);
    tick();
    tick();
    chk("brk_p", 1'b1, 2'b11, 16'h01FD, 2'b10, S_PUSHB);
    tick();
    chk("brk_vec_l", 1'b1, 2'b11, 16'hFFFE, 2'b00, S_VL);
    tick();
    chk("brk_vec_h", 1'b1, 2'b11, 16'hFFFF, 2'b00, S_VH);
    tick();
    chk("brk_idle", 1'b0, 2'b00, 16'h0000, 2'b00, S_NONE);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
